frame_buffer: RTL and testbench

Pixel store sitting between the GPU's framebuffer write port and the display scanout. Accepts single-pixel writes (x, y, RGB565) from the GPU and serves pixels to the video timing generator, upscaling the stored image by 2^SCALE_SHIFT in each axis. Optionally double-buffered, with buffer swaps deferred to vertical blanking.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_ram.sv | 35 +++
 rtl/frame_buffer.sv | 157 +++++++++++++++
 tb/tb_frame_buffer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Brief    : Shared frame-buffer geometry defaults, pixel type and swap states.
// Revision : 1.0
// ============================================================================
package fb_pkg;

    localparam int FB_WIDTH_DEF  = 160;
    localparam int FB_HEIGHT_DEF = 120;
    localparam int FB_ADDR_W     = $clog2(FB_WIDTH_DEF * FB_HEIGHT_DEF);

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    function automatic int addr_width(input int width, input int height);
        return $clog2(width * height);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// ============================================================================
// Module   : fb_ram
// Brief    : Simple dual-port RAM, one write and one read port, read-first,
//            registered read output (block-RAM inferable).
// Revision : 1.0
// ============================================================================
module fb_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 19200
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_q;

    // Read and write share one process so a same-address collision returns old data.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer
// Brief    : GPU pixel store with 2^SCALE_SHIFT upscaled scanout; optional
//            double buffering via FRAME_BUFFER_DOUBLE_EN (swap at vblank rise).
// Revision : 1.0
// ============================================================================
module frame_buffer
    import fb_pkg::*;
#(
    parameter int FB_WIDTH    = FB_WIDTH_DEF,
    parameter int FB_HEIGHT   = FB_HEIGHT_DEF,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  fb_x,
    input  logic [7:0]  fb_y,
    input  logic [15:0] fb_color,
    input  logic        fb_write,
    input  logic [9:0]  scan_x,
    input  logic [9:0]  scan_y,
    input  logic        scan_active,
    input  logic        scan_vblank,
    input  logic        swap_req,
    output logic [15:0] px_color,
    output logic        px_valid,
    output logic        swap_pending,
    output logic        front_sel
);

    localparam int AW = addr_width(FB_WIDTH, FB_HEIGHT);
`ifdef FRAME_BUFFER_DOUBLE_EN
    localparam int SEL_W = 1;
`else
    localparam int SEL_W = 0;
`endif
    localparam int RAM_AW    = AW + SEL_W;
    localparam int RAM_DEPTH = (1 << SEL_W) * FB_WIDTH * FB_HEIGHT;

    logic              w_wr_ok;
    logic [AW-1:0]     w_wr_lin;
    logic [RAM_AW-1:0] w_wr_addr;
    logic [9:0]        w_src_x;
    logic [9:0]        w_src_y;
    logic              w_rd_inrange;
    logic [AW-1:0]     w_rd_lin;
    logic [RAM_AW-1:0] w_rd_addr;
    logic [15:0]       w_ram_rdata;

    logic [RAM_AW-1:0] rd_addr_q;
    logic              act1_q;
    logic              rng1_q;
    logic              act2_q;
    logic              rng2_q;

    assign w_wr_ok  = fb_write && (32'(fb_x) < FB_WIDTH) && (32'(fb_y) < FB_HEIGHT);
    assign w_wr_lin = AW'(fb_y) * AW'(FB_WIDTH) + AW'(fb_x);

    assign w_src_x      = scan_x >> SCALE_SHIFT;
    assign w_src_y      = scan_y >> SCALE_SHIFT;
    assign w_rd_inrange = (32'(w_src_x) < FB_WIDTH) && (32'(w_src_y) < FB_HEIGHT);
    assign w_rd_lin     = AW'(w_src_y) * AW'(FB_WIDTH) + AW'(w_src_x);

`ifdef FRAME_BUFFER_DOUBLE_EN
    swap_state_t state_q, state_d;
    logic        front_q, front_d;
    logic        vblank_q;
    logic        w_vb_rise;

    assign w_vb_rise = scan_vblank & ~vblank_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= SWAP_IDLE;
            front_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            front_q  <= front_d;
            vblank_q <= scan_vblank;
        end
    end

    // A request coinciding with the vblank rise swaps immediately.
    always_comb begin
        state_d = state_q;
        front_d = front_q;
        case (state_q)
            SWAP_IDLE: begin
                if (swap_req) begin
                    if (w_vb_rise) begin
                        front_d = ~front_q;
                    end else begin
                        state_d = SWAP_PENDING;
                    end
                end
            end
            SWAP_PENDING: begin
                if (w_vb_rise) begin
                    front_d = ~front_q;
                    state_d = SWAP_IDLE;
                end
            end
            default: state_d = SWAP_IDLE;
        endcase
    end

    assign swap_pending = (state_q == SWAP_PENDING);
    assign front_sel    = front_q;
    assign w_wr_addr    = {~front_q, w_wr_lin};
    assign w_rd_addr    = {front_q, w_rd_lin};
`else
    logic unused_swap_inputs;

    assign unused_swap_inputs = ^{swap_req, scan_vblank};
    assign swap_pending       = 1'b0;
    assign front_sel          = 1'b0;
    assign w_wr_addr          = w_wr_lin;
    assign w_rd_addr          = w_rd_lin;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_addr_q <= '0;
            act1_q    <= 1'b0;
            rng1_q    <= 1'b0;
            act2_q    <= 1'b0;
            rng2_q    <= 1'b0;
        end else begin
            rd_addr_q <= w_rd_addr;
            act1_q    <= scan_active;
            rng1_q    <= w_rd_inrange;
            act2_q    <= act1_q;
            rng2_q    <= rng1_q;
        end
    end

    fb_ram #(
        .DATA_W (16),
        .ADDR_W (RAM_AW),
        .DEPTH  (RAM_DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (w_wr_ok),
        .wr_addr_i (w_wr_addr),
        .wr_data_i (fb_color),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (w_ram_rdata)
    );

    // RAM output is not reset; the delayed flags gate it to zero.
    assign px_valid = act2_q;
    assign px_color = (act2_q && rng2_q) ? w_ram_rdata : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buffer
// Brief    : Directed scoreboard bench for frame_buffer (single or double build).
// Revision : 1.0
// ============================================================================
module tb_frame_buffer;

`ifdef FRAME_BUFFER_DOUBLE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  fb_x;
    logic [7:0]  fb_y;
    logic [15:0] fb_color;
    logic        fb_write;
    logic [9:0]  scan_x;
    logic [9:0]  scan_y;
    logic        scan_active;
    logic        scan_vblank;
    logic        swap_req;
    logic [15:0] px_color;
    logic        px_valid;
    logic        swap_pending;
    logic        front_sel;

    always #5 clk = ~clk;

    frame_buffer dut (
        .clk          (clk),
        .rstn         (rstn),
        .fb_x         (fb_x),
        .fb_y         (fb_y),
        .fb_color     (fb_color),
        .fb_write     (fb_write),
        .scan_x       (scan_x),
        .scan_y       (scan_y),
        .scan_active  (scan_active),
        .scan_vblank  (scan_vblank),
        .swap_req     (swap_req),
        .px_color     (px_color),
        .px_valid     (px_valid),
        .swap_pending (swap_pending),
        .front_sel    (front_sel)
    );

    typedef struct {
        int          due;
        logic [15:0] color;
        logic        valid;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] model [0:1][0:19199];
    logic        m_front = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
                check({e.tag, ".late"}, cyc, e.due);
            end else begin
                check({e.tag, ".valid"}, {31'd0, px_valid}, {31'd0, e.valid});
                check({e.tag, ".color"}, {16'd0, px_color}, {16'd0, e.color});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input logic [15:0] c);
        logic back;
        back     = DBL ? ~m_front : 1'b0;
        fb_x     = 8'(x);
        fb_y     = 8'(y);
        fb_color = c;
        fb_write = 1'b1;
        if (x < 160 && y < 120) model[back][y * 160 + x] = c;
        step();
        fb_write = 1'b0;
    endtask

    task automatic scan(input int x, input int y, input bit act, input string tag);
        exp_t e;
        int   sx;
        int   sy;
        sx      = x >> 2;
        sy      = y >> 2;
        e.due   = cyc + 2;
        e.valid = act;
        e.tag   = tag;
        if (!act || sx >= 160 || sy >= 120) e.color = 16'h0000;
        else e.color = model[m_front][sy * 160 + sx];
        sb.push_back(e);
        scan_x      = 10'(x);
        scan_y      = 10'(y);
        scan_active = act;
        step();
        scan_active = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            step();
            n++;
        end
        check({tag, ".drain"}, sb.size(), 0);
    endtask

    task automatic publish();
`ifdef FRAME_BUFFER_DOUBLE_EN
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("pub.pending", {31'd0, swap_pending}, 1);
        scan_vblank = 1'b1;
        step();
        m_front = ~m_front;
        check("pub.front", {31'd0, front_sel}, {31'd0, m_front});
        check("pub.pending_clr", {31'd0, swap_pending}, 0);
        scan_vblank = 1'b0;
        step();
`else
        step();
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn        = 1'b0;
        fb_x        = '0;
        fb_y        = '0;
        fb_color    = '0;
        fb_write    = 1'b0;
        scan_x      = '0;
        scan_y      = '0;
        scan_active = 1'b0;
        scan_vblank = 1'b0;
        swap_req    = 1'b0;
        step();
        step();
        check("rst.px_color", {16'd0, px_color}, 0);
        check("rst.px_valid", {31'd0, px_valid}, 0);
        check("rst.swap_pending", {31'd0, swap_pending}, 0);
        check("rst.front_sel", {31'd0, front_sel}, 0);
        rstn = 1'b1;
        step();

        // Write and read back, corners and out-of-image source coordinates
        wr(0, 0, 16'hF800);
        wr(159, 119, 16'h07E0);
        publish();
        scan(0, 0, 1'b1, "rb00");
        scan(636, 476, 1'b1, "rb_max");
        scan(640, 0, 1'b1, "rb_xoob");
        scan(0, 480, 1'b1, "rb_yoob");
        drain("rb");

        // Upscale: 4x4 block maps to one source pixel
        wr(3, 2, 16'h1234);
        wr(4, 2, 16'h5678);
        publish();
        for (int y = 8; y < 12; y++) begin
            for (int x = 12; x < 16; x++) begin
                scan(x, y, 1'b1, $sformatf("up_%0d_%0d", x, y));
            end
        end
        scan(16, 8, 1'b1, "up_next");
        drain("up");

        // Out-of-range write must not alias onto (0,6)
        wr(0, 5, 16'h0F0F);
        wr(0, 6, 16'h0606);
        wr(160, 5, 16'hFFFF);
        publish();
        scan(0, 20, 1'b1, "oor_0_5");
        scan(0, 24, 1'b1, "oor_0_6");
        drain("oor");

`ifdef FRAME_BUFFER_DOUBLE_EN
        wr(1, 1, 16'h1111);
        publish();
        wr(1, 1, 16'hAAAA);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("sw.pending", {31'd0, swap_pending}, 1);
        scan(4, 4, 1'b1, "sw_pre");
        drain("sw_pre");
        scan_vblank = 1'b1;
        step();
        m_front = ~m_front;
        check("sw.front", {31'd0, front_sel}, 1);
        check("sw.pending_clr", {31'd0, swap_pending}, 0);
        scan_vblank = 1'b0;
        scan(4, 4, 1'b1, "sw_post");
        drain("sw_post");

        // Two requests while pending: exactly one toggle
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("dbl.pending", {31'd0, swap_pending}, 1);
        scan_vblank = 1'b1;
        step();
        m_front = ~m_front;
        check("dbl.front", {31'd0, front_sel}, {31'd0, m_front});
        scan_vblank = 1'b0;
        step();
        scan_vblank = 1'b1;
        step();
        check("dbl.no_second", {31'd0, front_sel}, {31'd0, m_front});
        check("dbl.idle", {31'd0, swap_pending}, 0);
        scan_vblank = 1'b0;
        step();
`else
        wr(1, 1, 16'hAAAA);
        scan(4, 4, 1'b1, "sb_rd");
        drain("sb_rd");
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("sb.pending", {31'd0, swap_pending}, 0);
        scan_vblank = 1'b1;
        step();
        check("sb.front", {31'd0, front_sel}, 0);
        scan_vblank = 1'b0;
        step();
`endif

        // Blanking
        scan(4, 4, 1'b0, "blank_a");
        scan(636, 476, 1'b0, "blank_b");
        drain("blank");

        // Reset with a swap outstanding
        publish();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("rs.pending_pre", {31'd0, swap_pending}, DBL ? 1 : 0);
        rstn = 1'b0;
        step();
        check("rs.pending", {31'd0, swap_pending}, 0);
        check("rs.front", {31'd0, front_sel}, 0);
        check("rs.px_valid", {31'd0, px_valid}, 0);
        check("rs.px_color", {16'd0, px_color}, 0);
        m_front = 1'b0;
        rstn = 1'b1;
        step();
        scan_vblank = 1'b1;
        step();
        check("rs.no_swap_front", {31'd0, front_sel}, 0);
        check("rs.no_swap_pending", {31'd0, swap_pending}, 0);
        scan_vblank = 1'b0;
        scan(4, 4, 1'b1, "rs_read");
        drain("rs_read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
